i2c_eeprom_ctrl: RTL and testbench

//  Single-master I2C transaction sequencer for a 24xx-style EEPROM with 8-bit word address.

---
 rtl/i2c_eeprom_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_i2c_eeprom_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_ctrl.sv
// Single-master I2C sequencer for a 24xx EEPROM with an 8-bit word address.
// Runs one byte write, or one random read, per accepted request.
module i2c_eeprom_ctrl #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned I2C_HZ   = 100_000,
   parameter logic [6:0]  DEV_ADDR = 7'h50
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] mem_addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in
);

   localparam int unsigned QDIV = CLK_HZ / (4 * I2C_HZ);
   localparam int unsigned CW   = (QDIV > 1) ? $clog2(QDIV) : 1;

   typedef enum logic [2:0] {
      StIdle, StStart, StRstart, StTx, StAck, StRx, StNack, StStop
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      quarter_q, quarter_d;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      phase_q, phase_d;
   logic [7:0]      tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic            samp_q, samp_d;
   logic            rw_q;
   logic [7:0]      addr_q, wdata_q;
   logic            tick, set_err, finish;
   logic [1:0]      bus_d;

   // Returns {scl, sda_oe} for a given slot type and quarter.
   function automatic logic [1:0] slot_out(input state_e st, input logic [1:0] q,
                                           input logic bit_val);
      slot_out = 2'b10;
      case (st)
         StStart:  slot_out = (q == 2'd3) ? 2'b01 : (q == 2'd2) ? 2'b11 : 2'b10;
         StRstart: slot_out = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b10 : {~q[0], 1'b1};
         StStop:   slot_out = (q == 2'd0) ? 2'b01 : (q == 2'd1) ? 2'b11 : 2'b10;
         StTx:     slot_out = {q[1], ~bit_val};
         StAck, StRx, StNack: slot_out = {q[1], 1'b0};
         default:  slot_out = 2'b10;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      quarter_d = quarter_q;
      bit_d     = bit_q;
      phase_d   = phase_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      samp_d    = samp_q;
      set_err   = 1'b0;
      finish    = 1'b0;
      tick      = (state_q != StIdle) && (cnt_q == CW'(QDIV - 1));
      if (tick) begin
         quarter_d = quarter_q + 2'd1;
         if (quarter_q == 2'd2) begin
            samp_d = sda_in;
            if (state_q == StRx) rx_d = {rx_q[6:0], sda_in};
         end
         if (quarter_q == 2'd3) begin
            case (state_q)
               StStart: begin
                  state_d = StTx;
                  tx_d    = {DEV_ADDR, 1'b0};
                  bit_d   = 3'd7;
                  phase_d = 2'd0;
               end
               StRstart: begin
                  state_d = StTx;
                  tx_d    = {DEV_ADDR, 1'b1};
                  bit_d   = 3'd7;
                  phase_d = 2'd2;
               end
               StTx: begin
                  if (bit_q == 3'd0) begin
                     state_d = StAck;
                  end else begin
                     bit_d = bit_q - 3'd1;
                     tx_d  = {tx_q[6:0], 1'b0};
                  end
               end
               StAck: begin
                  // phase counts address/data bytes already acknowledged
                  if (samp_q) begin
                     state_d = StStop;
                     set_err = 1'b1;
                  end else if (phase_q == 2'd0) begin
                     state_d = StTx;
                     tx_d    = addr_q;
                     bit_d   = 3'd7;
                     phase_d = 2'd1;
                  end else if (phase_q == 2'd1) begin
                     if (rw_q) begin
                        state_d = StRstart;
                     end else begin
                        state_d = StTx;
                        tx_d    = wdata_q;
                        bit_d   = 3'd7;
                        phase_d = 2'd2;
                     end
                  end else begin
                     state_d = rw_q ? StRx : StStop;
                     bit_d   = 3'd7;
                  end
               end
               StRx: begin
                  if (bit_q == 3'd0) state_d = StNack;
                  else bit_d = bit_q - 3'd1;
               end
               StNack: state_d = StStop;
               StStop: begin
                  state_d = StIdle;
                  finish  = 1'b1;
               end
               default: state_d = StIdle;
            endcase
         end
      end
      bus_d = slot_out(state_d, quarter_d, tx_d[7]);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q   <= StIdle;
         quarter_q <= 2'd0;
         cnt_q     <= '0;
         bit_q     <= 3'd0;
         phase_q   <= 2'd0;
         tx_q      <= 8'h00;
         rx_q      <= 8'h00;
         samp_q    <= 1'b0;
         rw_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         rdata     <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         scl       <= 1'b1;
         sda_oe    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state_q == StIdle) begin
            cnt_q <= '0;
            // busy is still high in the done cycle, which blocks a same-cycle start
            if (start && !busy) begin
               state_q   <= StStart;
               quarter_q <= 2'd0;
               rw_q      <= rw;
               addr_q    <= mem_addr;
               wdata_q   <= wdata;
               busy      <= 1'b1;
               ack_err   <= 1'b0;
               scl       <= 1'b1;
               sda_oe    <= 1'b0;
            end else begin
               busy <= 1'b0;
            end
         end else begin
            cnt_q     <= tick ? '0 : CW'(cnt_q + 1'b1);
            state_q   <= state_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            samp_q    <= samp_d;
            scl       <= bus_d[1];
            sda_oe    <= bus_d[0];
            if (set_err) ack_err <= 1'b1;
            if (finish) begin
               done <= 1'b1;
               if (rw_q && !ack_err) rdata <= rx_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
// Directed bench for i2c_eeprom_ctrl with a behavioural EEPROM slave on the bus.
module tb_i2c_eeprom_ctrl;

   localparam int TOK_START = 256;
   localparam int TOK_STOP  = 512;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       start, rw;
   logic [7:0] mem_addr, wdata, rdata;
   logic       busy, done, ack_err, scl, sda_oe, sda_in;
   logic       slave_pull = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int clk_cnt = 0;
   int bus_log[$];
   int exp_q[$];
   int rise_cnt, last_rise, first_period;
   logic ack_en, mack;
   logic [7:0] rd_val;
   int got_cyc;

   assign sda_in = !(sda_oe || slave_pull);

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) clk_cnt <= clk_cnt + 1;

   i2c_eeprom_ctrl #(.CLK_HZ(1600), .I2C_HZ(100), .DEV_ADDR(7'h50)) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .start    (start),
      .rw       (rw),
      .mem_addr (mem_addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .scl      (scl),
      .sda_oe   (sda_oe),
      .sda_in   (sda_in)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, bus_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_tok%0d", tag, i), (i < bus_log.size()) ? bus_log[i] : -1, exp_q[i]);
   endtask

   // Slave: logs START/STOP and every byte on the bus, ACKs when ack_en, answers reads
   initial begin : slave
      logic pscl, psda, cscl, csda, stx, rd_next;
      logic [7:0] sreg, tbyte;
      int sbit, sbyte;
      pscl = 1'b1; psda = 1'b1; stx = 1'b0; rd_next = 1'b0;
      sreg = 8'h00; tbyte = 8'h00; sbit = 0; sbyte = 0;
      forever begin
         @(negedge clk_in);
         cscl = scl;
         csda = sda_in;
         if (cscl && pscl && psda && !csda) begin
            bus_log.push_back(TOK_START);
            sbit = 0; sbyte = 0; stx = 1'b0; rd_next = 1'b0; slave_pull = 1'b0;
         end else if (cscl && pscl && !psda && csda) begin
            bus_log.push_back(TOK_STOP);
            sbit = 0; stx = 1'b0; slave_pull = 1'b0;
         end else if (cscl && !pscl) begin
            rise_cnt++;
            if (rise_cnt == 2) first_period = clk_cnt - last_rise;
            last_rise = clk_cnt;
            if (sbit < 8) begin
               sreg = {sreg[6:0], csda};
               sbit++;
               if (sbit == 8) bus_log.push_back(int'(sreg));
            end else if (sbit == 8) begin
               if (stx) mack = csda;
               sbit = 9;
            end
         end else if (!cscl && pscl) begin
            if (sbit == 8 && !stx) begin
               slave_pull = ack_en;
               if (sbyte == 0 && sreg[0]) rd_next = ack_en;
               sbyte++;
            end else if (sbit == 8 && stx) begin
               slave_pull = 1'b0;
            end else if (sbit == 9) begin
               sbit = 0;
               slave_pull = 1'b0;
               stx = 1'b0;
               if (rd_next) begin
                  stx = 1'b1;
                  rd_next = 1'b0;
                  tbyte = rd_val;
                  slave_pull = !tbyte[7];
               end
            end else if (stx && sbit >= 1 && sbit <= 7) begin
               slave_pull = !tbyte[7 - sbit];
            end
         end
         pscl = cscl;
         psda = csda;
      end
   end

   task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                          input bit repulse, output int dcyc);
      int cyc;
      bus_log.delete();
      rise_cnt = 0;
      first_period = 0;
      rw = r; mem_addr = a; wdata = d; start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      cyc = 1;
      check("busy_after_accept", busy, 1'b1);
      check("ack_err_cleared", ack_err, 1'b0);
      while (!done && cyc < 2000) begin
         if (repulse && cyc == 50) begin
            start = 1'b1; mem_addr = 8'h77; rw = ~r; wdata = 8'h00;
         end else begin
            start = 1'b0;
         end
         @(posedge clk_in); #1;
         cyc++;
      end
      start = 1'b0;
      if (!done) check("done_timeout", 1'b0, 1'b1);
      dcyc = cyc;
      check("busy_in_done", busy, 1'b1);
      if (repulse) start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      check("busy_after_done", busy, 1'b0);
      check("done_one_pulse", done, 1'b0);
      repeat (4) @(posedge clk_in);
      #1;
   endtask

   initial begin
      int cyc;
      reset = 1'b1; start = 1'b0; rw = 1'b0; mem_addr = 8'h00; wdata = 8'h00;
      ack_en = 1'b1; rd_val = 8'h00; mack = 1'b0;
      rise_cnt = 0; last_rise = 0; first_period = 0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_scl", scl, 1'b1);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ack_err", ack_err, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      reset = 1'b0;
      repeat (5) @(posedge clk_in);
      #1;

      // 1: byte write
      run_txn(1'b0, 8'h3C, 8'hA5, 1'b0, got_cyc);
      check("t1_done_cyc", got_cyc, 465);
      check("t1_ack_err", ack_err, 1'b0);
      exp_q = '{TOK_START, 'hA0, 'h3C, 'hA5, TOK_STOP};
      check_log("t1");
      check("t1_scl_period", first_period, 16);
      check("t1_scl_rises", rise_cnt, 28);

      // 2: random read
      rd_val = 8'h5A;
      mack = 1'b0;
      run_txn(1'b1, 8'h10, 8'h00, 1'b0, got_cyc);
      check("t2_done_cyc", got_cyc, 625);
      check("t2_rdata", rdata, 8'h5A);
      check("t2_ack_err", ack_err, 1'b0);
      check("t2_master_nack", mack, 1'b1);
      exp_q = '{TOK_START, 'hA0, 'h10, TOK_START, 'hA1, 'h5A, TOK_STOP};
      check_log("t2");
      check("t2_scl_rises", rise_cnt, 38);

      // 3: no device answers
      ack_en = 1'b0;
      rd_val = 8'hC3;
      run_txn(1'b1, 8'h44, 8'h00, 1'b0, got_cyc);
      check("t3_done_cyc", got_cyc, 177);
      check("t3_ack_err", ack_err, 1'b1);
      check("t3_rdata_kept", rdata, 8'h5A);
      exp_q = '{TOK_START, 'hA0, TOK_STOP};
      check_log("t3");
      ack_en = 1'b1;

      // 4: start re-pulsed mid-transaction and in the done cycle
      run_txn(1'b0, 8'h21, 8'h9E, 1'b1, got_cyc);
      check("t4_done_cyc", got_cyc, 465);
      check("t4_rdata_kept", rdata, 8'h5A);
      exp_q = '{TOK_START, 'hA0, 'h21, 'h9E, TOK_STOP};
      check_log("t4");

      // 5: reset during the fourth MADDR bit slot
      rw = 1'b0; mem_addr = 8'h3C; wdata = 8'hA5; start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 216) begin
         @(posedge clk_in); #1;
         cyc++;
      end
      check("t5_scl_low_mid_bit", scl, 1'b0);
      reset = 1'b1;
      @(posedge clk_in); #1;
      check("t5_scl", scl, 1'b1);
      check("t5_sda_oe", sda_oe, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      check("t5_rdata", rdata, 8'h00);
      reset = 1'b0;
      repeat (20) @(posedge clk_in);
      #1;
      run_txn(1'b0, 8'h3C, 8'hA5, 1'b0, got_cyc);
      check("t5_done_cyc", got_cyc, 465);
      check("t5_ack_err", ack_err, 1'b0);
      exp_q = '{TOK_START, 'hA0, 'h3C, 'hA5, TOK_STOP};
      check_log("t5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
